// File: rtl/prog_truth_table.sv
// Run-time programmable N_IN-input truth table with a serial shadow-load
// port and a one-deep valid/ready output stage.
module prog_truth_table #(
  parameter int unsigned          N_IN    = 3,
  parameter logic [(2**N_IN)-1:0] TT_INIT = 8'h47
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_start,
  input  logic            cfg_bit_valid,
  input  logic            cfg_bit,
  output logic            cfg_busy,
  output logic            cfg_done,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N_IN-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_bit,
  output logic [N_IN-1:0] out_row,
  output logic [15:0]     ones_cnt
);

  localparam int unsigned TT_W   = 2**N_IN;
  localparam int unsigned BCNT_W = N_IN + 1;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [TT_W-1:0]     sh_q, sh_d;
  logic [TT_W-1:0]     act_q, act_d;
  logic                commit_c;
  logic                accept_c;
  logic                out_hs_c;

  // Load FSM next-state: restart has priority over a bit, last bit commits
  always_comb begin
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    sh_d     = sh_q;
    act_d    = act_q;
    commit_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_d = LOAD;
          bcnt_d  = '0;
        end
      end
      LOAD: begin
        if (cfg_start) begin
          bcnt_d = '0;
        end else if (cfg_bit_valid) begin
          sh_d   = {sh_q[TT_W-2:0], cfg_bit};
          bcnt_d = bcnt_q + BCNT_W'(1);
          if (bcnt_q == BCNT_W'(TT_W - 1)) begin
            act_d    = {sh_q[TT_W-2:0], cfg_bit};
            state_d  = IDLE;
            commit_c = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Configuration registers and the post-commit done pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bcnt_q   <= '0;
      sh_q     <= '0;
      act_q    <= TT_INIT;
      cfg_done <= 1'b0;
    end else begin
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      sh_q     <= sh_d;
      act_q    <= act_d;
      cfg_done <= commit_c;
    end
  end

  assign cfg_busy = (state_q == LOAD);
  assign in_ready = !out_valid || out_ready;
  assign accept_c = in_valid && in_ready;
  assign out_hs_c = out_valid && out_ready;

  // Output stage; row r lives at bit TT_W-1-r, which is simply ~r.
  // act_q is read before its commit update, so a commit-edge accept sees the old table.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_row   <= '0;
    end else if (accept_c) begin
      out_valid <= 1'b1;
      out_bit   <= act_q[~in_data];
      out_row   <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating count of delivered ones
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ones_cnt <= '0;
    end else if (out_hs_c && out_bit && (ones_cnt != 16'hFFFF)) begin
      ones_cnt <= ones_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_prog_truth_table.sv
// Self-checking bench for prog_truth_table: N_IN=3 feature tests plus
// N_IN=1 (saturation) and N_IN=6 (random table) sweeps run concurrently.
module tb_prog_truth_table;

  localparam logic [7:0]  TT3 = 8'h47;
  localparam logic [1:0]  TT1 = 2'b01;
  localparam logic [63:0] TT6 = 64'hD1B5_4A32_9E07_C6F3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // N_IN = 3 instance
  logic       rst_n, cfg_start, cfg_bit_valid, cfg_bit, cfg_busy, cfg_done;
  logic       in_valid, in_ready, out_valid, out_ready, out_bit;
  logic [2:0] in_data, out_row;
  logic [15:0] ones_cnt;
  // N_IN = 1 instance
  logic       rst_1, cfg_start_1, cfg_bit_valid_1, cfg_bit_1, cfg_busy_1, cfg_done_1;
  logic       in_valid_1, in_ready_1, out_valid_1, out_ready_1, out_bit_1;
  logic [0:0] in_data_1, out_row_1;
  logic [15:0] ones_cnt_1;
  // N_IN = 6 instance
  logic       rst_6, cfg_start_6, cfg_bit_valid_6, cfg_bit_6, cfg_busy_6, cfg_done_6;
  logic       in_valid_6, in_ready_6, out_valid_6, out_ready_6, out_bit_6;
  logic [5:0] in_data_6, out_row_6;
  logic [15:0] ones_cnt_6;

  prog_truth_table #(.N_IN(3), .TT_INIT(TT3)) u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_bit_valid(cfg_bit_valid),
    .cfg_bit(cfg_bit), .cfg_busy(cfg_busy), .cfg_done(cfg_done), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_bit(out_bit), .out_row(out_row), .ones_cnt(ones_cnt));

  prog_truth_table #(.N_IN(1), .TT_INIT(TT1)) u_dut1 (
    .clk(clk), .rst_n(rst_1), .cfg_start(cfg_start_1), .cfg_bit_valid(cfg_bit_valid_1),
    .cfg_bit(cfg_bit_1), .cfg_busy(cfg_busy_1), .cfg_done(cfg_done_1), .in_valid(in_valid_1),
    .in_ready(in_ready_1), .in_data(in_data_1), .out_valid(out_valid_1), .out_ready(out_ready_1),
    .out_bit(out_bit_1), .out_row(out_row_1), .ones_cnt(ones_cnt_1));

  prog_truth_table #(.N_IN(6), .TT_INIT(TT6)) u_dut6 (
    .clk(clk), .rst_n(rst_6), .cfg_start(cfg_start_6), .cfg_bit_valid(cfg_bit_valid_6),
    .cfg_bit(cfg_bit_6), .cfg_busy(cfg_busy_6), .cfg_done(cfg_done_6), .in_valid(in_valid_6),
    .in_ready(in_ready_6), .in_data(in_data_6), .out_valid(out_valid_6), .out_ready(out_ready_6),
    .out_bit(out_bit_6), .out_row(out_row_6), .ones_cnt(ones_cnt_6));

  // Reference state for the N_IN=3 instance
  logic [7:0] tt_model;
  int         ones_model;

  // Row r of a W-entry table is bit W-1-r (row 0 is the MSB)
  function automatic logic tt_bit(input logic [63:0] tbl, input int w, input int row);
    return tbl[w - 1 - row];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus-only table load on the N_IN=3 instance
  task automatic load_main(input logic [7:0] v);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      cfg_bit_valid = 1'b1;
      cfg_bit       = v[k];
      tick();
    end
    cfg_bit_valid = 1'b0;
    tick();
    tt_model = v;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst_1 = 1'b0; rst_6 = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({cfg_busy, cfg_done, in_ready, out_valid, out_bit, out_row, ones_cnt} !== {3'b001, 2'b00, 3'd0, 16'd0}) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b done=%b rdy=%b ov=%b ob=%b row=%0d cnt=%0d, exp 0 0 1 0 0 0 0",
               cfg_busy, cfg_done, in_ready, out_valid, out_bit, out_row, ones_cnt);
    end
    rst_n = 1'b1; rst_1 = 1'b1; rst_6 = 1'b1;
    tick();
    n_checks++;
    if ({in_ready, out_valid, out_valid_1, out_valid_6, cfg_busy} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_release: got rdy=%b ov=%b ov1=%b ov6=%b busy=%b, exp 1 0 0 0 0",
               in_ready, out_valid, out_valid_1, out_valid_6, cfg_busy);
    end
    tt_model   = TT3;
    ones_model = 0;
  endtask

  task automatic test_default_table();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 3'd0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      n_checks++;
      if ({in_ready, out_valid, out_bit, out_row} !== {2'b11, tt_bit(64'(TT3), 8, i - 1), 3'(i - 1)}) begin
        n_fail++;
        $display("FAIL default_row%0d: got rdy=%b ov=%b ob=%b row=%0d, exp rdy=1 ov=1 ob=%b row=%0d",
                 i - 1, in_ready, out_valid, out_bit, out_row, tt_bit(64'(TT3), 8, i - 1), i - 1);
      end
      ones_model += int'(tt_bit(64'(TT3), 8, i - 1));
      if (i < 8) in_data = 3'(i);
      else       in_valid = 1'b0;
    end
    tick();
    n_checks++;
    if ({out_valid, ones_cnt} !== {1'b0, 16'(ones_model)} || ones_model != 4) begin
      n_fail++;
      $display("FAIL default_ones: got ov=%b cnt=%0d, exp ov=0 cnt=4", out_valid, ones_cnt);
    end
  endtask

  task automatic test_reload();
    logic [7:0] v = 8'h96;
    int busy_cnt = 0;
    int done_cnt = 0;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      busy_cnt += int'(cfg_busy);
      done_cnt += int'(cfg_done);
      cfg_bit_valid = 1'b1;
      cfg_bit       = v[k];
      tick();
    end
    cfg_bit_valid = 1'b0;
    n_checks++;
    if ({cfg_busy, cfg_done} !== 2'b01) begin
      n_fail++;
      $display("FAIL reload_commit: got busy=%b done=%b, exp busy=0 done=1", cfg_busy, cfg_done);
    end
    done_cnt += int'(cfg_done);
    for (int k = 0; k < 3; k++) begin
      tick();
      busy_cnt += int'(cfg_busy);
      done_cnt += int'(cfg_done);
    end
    n_checks++;
    if (busy_cnt != 8 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL reload_busy_done: got busy_cycles=%0d done_pulses=%0d, exp 8 and 1", busy_cnt, done_cnt);
    end
    tt_model = v;
    in_valid = 1'b1;
    in_data  = 3'b000;
    tick();
    n_checks++;
    if ({out_valid, out_bit, out_row} !== {1'b1, 1'b1, 3'b000}) begin
      n_fail++;
      $display("FAIL reload_row0: got ov=%b ob=%b row=%0d, exp 1 1 0", out_valid, out_bit, out_row);
    end
    in_data = 3'b111;
    tick();
    n_checks++;
    if ({out_valid, out_bit, out_row} !== {1'b1, 1'b0, 3'b111}) begin
      n_fail++;
      $display("FAIL reload_row7: got ov=%b ob=%b row=%0d, exp 1 0 7", out_valid, out_bit, out_row);
    end
    in_valid = 1'b0;
    tick();
    ones_model += 1;
  endtask

  task automatic test_commit_coherence();
    load_main(8'h47);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cfg_bit_valid = 1'b1;
      cfg_bit       = 1'b1;
      if (k == 7) begin
        in_valid = 1'b1;
        in_data  = 3'b011;
      end
      tick();
    end
    cfg_bit_valid = 1'b0;
    n_checks++;
    if ({cfg_done, out_valid, out_bit, out_row} !== {2'b11, tt_bit(64'(TT3), 8, 3), 3'b011}) begin
      n_fail++;
      $display("FAIL commit_old_table: got done=%b ov=%b ob=%b row=%0d, exp 1 1 0 3",
               cfg_done, out_valid, out_bit, out_row);
    end
    tick();
    n_checks++;
    if ({cfg_done, out_valid, out_bit, out_row} !== {3'b011, 3'b011}) begin
      n_fail++;
      $display("FAIL commit_new_table: got done=%b ov=%b ob=%b row=%0d, exp 0 1 1 3",
               cfg_done, out_valid, out_bit, out_row);
    end
    in_valid = 1'b0;
    tick();
    ones_model += 1;
    tt_model = 8'hFF;
    n_checks++;
    if (ones_cnt !== 16'(ones_model)) begin
      n_fail++;
      $display("FAIL commit_ones: got %0d exp %0d", ones_cnt, ones_model);
    end
  endtask

  // Scoreboarded stream; mode 1 stalls the sink for 5 cycles after the first result
  task automatic test_stream(input string tag, input int n, input int mode);
    logic [3:0] q[$];
    int   sent = 0, got = 0, cyc = 0, stall_from = -1;
    logic acc, hs, exp_rdy;
    while (got < n && cyc < n * 20 + 50) begin
      in_valid = (sent < n) && (mode == 1 || $urandom_range(0, 3) != 0);
      in_data  = 3'($urandom);
      if (mode == 1) out_ready = !(stall_from >= 0 && cyc >= stall_from && cyc < stall_from + 5);
      else           out_ready = ($urandom_range(0, 2) != 0);
      #1;
      exp_rdy = (q.size() == 0) || out_ready;
      n_checks++;
      if ({out_valid, in_ready} !== {q.size() != 0, exp_rdy}) begin
        n_fail++;
        $display("FAIL %s_flow cyc%0d: got ov=%b rdy=%b, exp ov=%b rdy=%b",
                 tag, cyc, out_valid, in_ready, q.size() != 0, exp_rdy);
      end
      if (q.size() != 0) begin
        n_checks++;
        if ({out_bit, out_row} !== q[0]) begin
          n_fail++;
          $display("FAIL %s_data cyc%0d: got ob=%b row=%0d, exp ob=%b row=%0d",
                   tag, cyc, out_bit, out_row, q[0][3], q[0][2:0]);
        end
      end
      acc = in_valid && exp_rdy;
      hs  = (q.size() != 0) && out_ready;
      if (hs) begin
        if (q[0][3] && ones_model < 65535) ones_model++;
        void'(q.pop_front());
        got++;
      end
      if (acc) begin
        q.push_back({tt_bit(64'(tt_model), 8, int'(in_data)), in_data});
        sent++;
        if (stall_from < 0) stall_from = cyc + 1;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (got != n || ones_cnt !== 16'(ones_model)) begin
      n_fail++;
      $display("FAIL %s_end: got results=%0d cnt=%0d, exp results=%0d cnt=%0d", tag, got, ones_cnt, n, ones_model);
    end
  endtask

  task automatic test_backpressure();
    load_main(8'h96);
    test_stream("backpressure", 12, 1);
  endtask

  task automatic test_random_traffic();
    load_main(8'($urandom));
    test_stream("random", 200, 0);
  endtask

  task automatic test_restart();
    int done_cnt = 0;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cfg_bit_valid = 1'b1;
      cfg_bit       = 1'b1;
      tick();
      done_cnt += int'(cfg_done);
    end
    cfg_start = 1'b1;
    tick();
    done_cnt += int'(cfg_done);
    cfg_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cfg_bit_valid = 1'b1;
      cfg_bit       = 1'b0;
      tick();
    end
    cfg_bit_valid = 1'b0;
    n_checks++;
    if ({done_cnt != 0, cfg_done, cfg_busy} !== 3'b010) begin
      n_fail++;
      $display("FAIL restart_done: got early_done=%0d done=%b busy=%b, exp 0 1 0", done_cnt, cfg_done, cfg_busy);
    end
    tick();
    tt_model = 8'h00;
    test_stream("restart", 40, 0);
  endtask

  task automatic test_abort();
    int done_cnt = 0;
    int busy_cnt = 0;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cfg_bit_valid = 1'b1;
      cfg_bit       = 1'b1;
      tick();
    end
    cfg_bit_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n      = 1'b1;
    tt_model   = TT3;
    ones_model = 0;
    n_checks++;
    if ({cfg_busy, cfg_done, out_valid, ones_cnt} !== {3'b000, 16'd0}) begin
      n_fail++;
      $display("FAIL abort_reset: got busy=%b done=%b ov=%b cnt=%0d, exp 0 0 0 0",
               cfg_busy, cfg_done, out_valid, ones_cnt);
    end
    for (int k = 0; k < 8; k++) begin
      cfg_bit_valid = (k < 5);
      cfg_bit       = 1'b1;
      tick();
      done_cnt += int'(cfg_done);
      busy_cnt += int'(cfg_busy);
    end
    cfg_bit_valid = 1'b0;
    n_checks++;
    if (done_cnt != 0 || busy_cnt != 0) begin
      n_fail++;
      $display("FAIL abort_no_done: got done_pulses=%0d busy_cycles=%0d, exp 0 and 0", done_cnt, busy_cnt);
    end
    test_stream("abort", 40, 0);
  endtask

  task automatic test_sweep_n1();
    logic [15:0] exp_cnt;
    out_ready_1 = 1'b1;
    in_valid_1  = 1'b1;
    in_data_1   = 1'b0;
    tick();
    n_checks++;
    if ({out_valid_1, out_bit_1, out_row_1} !== {1'b1, tt_bit(64'(TT1), 2, 0), 1'b0}) begin
      n_fail++;
      $display("FAIL n1_row0: got ov=%b ob=%b row=%0d, exp 1 0 0", out_valid_1, out_bit_1, out_row_1);
    end
    in_data_1 = 1'b1;
    tick();
    n_checks++;
    if ({out_valid_1, out_bit_1, out_row_1} !== {1'b1, tt_bit(64'(TT1), 2, 1), 1'b1}) begin
      n_fail++;
      $display("FAIL n1_row1: got ov=%b ob=%b row=%0d, exp 1 1 1", out_valid_1, out_bit_1, out_row_1);
    end
    in_valid_1 = 1'b0;
    tick();
    // force an all-ones table
    cfg_start_1 = 1'b1;
    tick();
    cfg_start_1     = 1'b0;
    cfg_bit_valid_1 = 1'b1;
    cfg_bit_1       = 1'b1;
    tick();
    tick();
    cfg_bit_valid_1 = 1'b0;
    n_checks++;
    if ({cfg_done_1, cfg_busy_1} !== 2'b10) begin
      n_fail++;
      $display("FAIL n1_load: got done=%b busy=%b, exp 1 0", cfg_done_1, cfg_busy_1);
    end
    tick();
    n_checks++;
    if ({cfg_done_1, ones_cnt_1} !== {1'b0, 16'd1}) begin
      n_fail++;
      $display("FAIL n1_done_once: got done=%b cnt=%0d, exp 0 1", cfg_done_1, ones_cnt_1);
    end
    // one prior one plus (k-1) delivered ones by sample k
    in_valid_1 = 1'b1;
    for (int k = 1; k <= 65540; k++) begin
      in_data_1 = 1'($urandom);
      tick();
      if (k == 1 || k == 2 || k == 65534 || k == 65535 || k == 65536 || k == 65540) begin
        exp_cnt = (k >= 65535) ? 16'hFFFF : 16'(k);
        n_checks++;
        if ({out_bit_1, ones_cnt_1} !== {1'b1, exp_cnt}) begin
          n_fail++;
          $display("FAIL n1_sat k=%0d: got ob=%b cnt=%h, exp ob=1 cnt=%h", k, out_bit_1, ones_cnt_1, exp_cnt);
        end
      end
    end
    in_valid_1 = 1'b0;
    tick();
    n_checks++;
    if ({out_valid_1, ones_cnt_1} !== {1'b0, 16'hFFFF}) begin
      n_fail++;
      $display("FAIL n1_sat_hold: got ov=%b cnt=%h, exp 0 ffff", out_valid_1, ones_cnt_1);
    end
  endtask

  task automatic test_sweep_n6();
    logic [63:0] tbl = TT6;
    logic [5:0]  d;
    logic        eb;
    int          ones6 = 0;
    out_ready_6 = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        tbl = {$urandom, $urandom};
        cfg_start_6 = 1'b1;
        tick();
        cfg_start_6 = 1'b0;
        for (int k = 63; k >= 0; k--) begin
          while ($urandom_range(0, 3) == 0) begin
            cfg_bit_valid_6 = 1'b0;
            tick();
          end
          cfg_bit_valid_6 = 1'b1;
          cfg_bit_6       = tbl[k];
          tick();
        end
        cfg_bit_valid_6 = 1'b0;
        n_checks++;
        if ({cfg_done_6, cfg_busy_6} !== 2'b10) begin
          n_fail++;
          $display("FAIL n6_load: got done=%b busy=%b, exp 1 0", cfg_done_6, cfg_busy_6);
        end
        tick();
      end
      for (int k = 0; k < 5000; k++) begin
        d          = 6'($urandom);
        eb         = tt_bit(tbl, 64, int'(d));
        in_data_6  = d;
        in_valid_6 = 1'b1;
        tick();
        n_checks++;
        if ({out_valid_6, out_bit_6, out_row_6} !== {1'b1, eb, d}) begin
          n_fail++;
          $display("FAIL n6_vec p%0d k%0d: got ov=%b ob=%b row=%0d, exp 1 %b %0d",
                   pass, k, out_valid_6, out_bit_6, out_row_6, eb, d);
        end
        ones6 += int'(eb);
      end
      in_valid_6 = 1'b0;
      tick();
    end
    n_checks++;
    if (ones_cnt_6 !== 16'(ones6)) begin
      n_fail++;
      $display("FAIL n6_ones: got %0d exp %0d", ones_cnt_6, ones6);
    end
  endtask

  initial begin
    cfg_start = 1'b0; cfg_bit_valid = 1'b0; cfg_bit = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_start_1 = 1'b0; cfg_bit_valid_1 = 1'b0; cfg_bit_1 = 1'b0;
    in_valid_1 = 1'b0; in_data_1 = '0; out_ready_1 = 1'b1;
    cfg_start_6 = 1'b0; cfg_bit_valid_6 = 1'b0; cfg_bit_6 = 1'b0;
    in_valid_6 = 1'b0; in_data_6 = '0; out_ready_6 = 1'b1;
    test_reset();
    fork
      begin
        test_default_table();
        test_reload();
        test_commit_coherence();
        test_backpressure();
        test_random_traffic();
        test_restart();
        test_abort();
      end
      test_sweep_n1();
      test_sweep_n6();
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_truth_table.md
# prog_truth_table

Parametrised, run-time-programmable successor to the fixed 3-input truth-table gates in the tested-circuit library. It evaluates an N_IN-input Boolean function from a stored 2^N_IN-bit truth table, with a registered valid/ready output stage. The table is reloaded through a serial configuration port into a shadow register and committed atomically, so evaluation never stalls. It sits between the stimulus generator and the response checker in circuit-characterisation benches.

## Interface
- N_IN, 3: number of function inputs; the table width is TT_W = 2^N_IN. Legal range 1..6.
- TT_INIT, 8'h47: truth table loaded at reset. Width TT_W. Row r (input value r) maps to bit TT[TT_W-1-r], so row 0 is the MSB.
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  reset, synchronous, active-low.
- cfg_start  in  1  one-cycle pulse that begins or restarts a table load.
- cfg_bit_valid  in  1  cfg_bit is valid this cycle.
- cfg_bit  in  1  table bit. Bits are sent MSB first, so row 0 comes first.
- cfg_busy  out  1  high while a load is in progress.
- cfg_done  out  1  one-cycle pulse in the cycle after the commit edge.
- in_valid  in  1  input vector is valid.
- in_ready  out  1  block accepts the input vector.
- in_data  in  N_IN  input vector; in1 is the MSB.
- out_valid  out  1  result is valid.
- out_ready  in  1  downstream accepts the result.
- out_bit  out  1  function value.
- out_row  out  N_IN  echo of the evaluated in_data.
- ones_cnt  out  16  saturating count of accepted results whose out_bit is 1.

## Operation
- Registers: active table `act_tt`, shadow table `sh_tt`, bit counter `bcnt` (N_IN+1 bits), load FSM.
- Load FSM has two states, IDLE and LOAD.
  - IDLE, cfg_start=1: go to LOAD, clear bcnt to 0.
  - LOAD, cfg_bit_valid=1: shift cfg_bit into `sh_tt` from the LSB side (`sh_tt <= {sh_tt[TT_W-2:0], cfg_bit}`) and increment bcnt.
  - LOAD, accepted bit is number TT_W (bcnt == TT_W-1 before the edge): on that edge `act_tt <= shifted sh_tt`, return to IDLE, and cfg_done pulses in the next cycle.
  - cfg_start in LOAD: restart. Clear bcnt and discard partial bits. cfg_start takes priority over a simultaneous cfg_bit_valid.
  - cfg_bit_valid in IDLE is ignored.
- cfg_busy = (state == LOAD).
- Evaluation:
  - Accept when in_valid && in_ready.
  - in_ready = !out_valid || out_ready, so the output stage is one entry deep with throughput 1/cycle.
  - On accept: out_bit <= act_tt[TT_W-1-in_data], out_row <= in_data, out_valid <= 1.
  - out_valid clears only on out_ready without a new accept.
  - While out_valid && !out_ready, out_bit and out_row stay stable.
- Commit coherence: an input accepted on the commit edge uses the old table. Inputs from the next cycle onward use the new table.
- ones_cnt increments on each output handshake (out_valid && out_ready) with out_bit=1, and saturates at 16'hFFFF.

## Timing
- Reset (rst_n=0 at a clock edge):
  - act_tt=TT_INIT, sh_tt=0, state=IDLE, bcnt=0
  - cfg_busy=0, cfg_done=0
  - out_valid=0, out_bit=0, out_row=0, ones_cnt=0
  - in_ready=1 from the first cycle after reset.
- Reset mid-load aborts the load. act_tt returns to TT_INIT and no cfg_done pulse occurs.
- Evaluation latency: 1 cycle from the accept edge to out_valid.
- Load latency: cfg_start plus TT_W valid bits (minimum TT_W+1 cycles), then cfg_done one cycle later.
- cfg_done is never high for two consecutive cycles.
- Evaluation is never stalled by configuration activity.

## Test plan
- Reset, default table 0x47:
  - Stimulus: apply in_data 0..7 back-to-back with out_ready=1.
  - Required: out_bit sequence 0,1,0,0,0,1,1,1 at one result per cycle; ones_cnt=4.
- Reload with 0x96:
  - Stimulus: cfg_start, then bits 1,0,0,1,0,1,1,0.
  - Required: cfg_busy high for 8 cycles, cfg_done one pulse; afterwards in_data 3'b000 gives 1 and 3'b111 gives 0.
- Commit coherence:
  - Stimulus: with table 0x47, send in_data 3'b011 on the commit edge of a 0xFF load.
  - Required: out_bit=0; the next in_data 3'b011 gives 1.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles after the first result.
  - Required: in_ready=0, out_bit/out_row stable, no loss or duplication; release drains in order.
- Restart and abort:
  - Stimulus A: cfg_start after 5 bits, then 8 bits of 0x00.
  - Required A: table becomes 0x00 and all outputs are 0.
  - Stimulus B: rst_n low after 3 bits of a load.
  - Required B: table is back to 0x47, cfg_done never pulses.
- Parameter sweep:
  - Stimulus: N_IN=1 with TT_INIT=2'b01; N_IN=6 with a random 64-bit table checked against a reference model over 10k random vectors.
  - Required: zero mismatches; ones_cnt saturates at 16'hFFFF under a forced all-ones table.
